// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmitter stream.
// Holds a grant for a full packet, then idles GAP_CYCLES before rearbitrating.
module uart_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]    m_axis_tid,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NUM_PORTS-1:0]   grant_nxt;
  logic [NUM_PORTS-1:0]   onehot;
  logic [IW-1:0]          tid_nxt;
  logic [IW-1:0]          last;
  logic [IW-1:0]          last_nxt;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          cand;
  logic                   found;
  logic [15:0]            gap_cnt;
  logic [15:0]            gap_nxt;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   done;

  // busy is a decode of the registered state
  assign busy = (state != IDLE);

  // Round-robin search starting one past the last granted port
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IW'((int'(last) + k) % NUM_PORTS);
      if (!found && s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    onehot       = '0;
    onehot[pick] = 1'b1;
  end

  // Select the granted port's stream signals
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (m_axis_tid == IW'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  // Pass-through only while transferring; everything else held at zero
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == XFER) begin
      m_axis_tdata  = sel_data;
      m_axis_tvalid = sel_valid;
      m_axis_tlast  = sel_last;
      s_axis_tready = grant & {NUM_PORTS{m_axis_tready}};
    end
  end

  assign done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Next-state logic: arbitrate, lock for the packet, then count the gap
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    tid_nxt   = m_axis_tid;
    last_nxt  = last;
    gap_nxt   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = XFER;
          grant_nxt = onehot;
          tid_nxt   = pick;
          last_nxt  = pick;
        end
      end
      XFER: begin
        if (done) begin
          grant_nxt = '0;
          gap_nxt   = '0;
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State register; reset leaves port 0 with first priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      m_axis_tid <= '0;
      last       <= IW'(NUM_PORTS - 1);
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      m_axis_tid <= tid_nxt;
      last       <= last_nxt;
      gap_cnt    <= gap_nxt;
    end
  end

endmodule
